// File: rtl/core_pkg.sv
// Shared definitions for the ID/EXE hazard controller: forwarding-select
// encodings and the scoreboard slot layout.
package core_pkg;

  localparam int REG_IDX_W = 4;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_EXE     = 2'd1;
  localparam logic [1:0] FWD_MEM     = 2'd2;

  // One scoreboard entry: the register-writing behaviour of an in-flight instruction.
  typedef struct packed {
    logic                 vld;
    logic                 wb_en;
    logic                 mem_r;
    logic [REG_IDX_W-1:0] dest;
  } sb_slot_t;

endpackage

// File: rtl/id_exe_hazard_ctrl_hz_match.sv
// Comparator of one scoreboard slot against one ID source operand.
module hz_match
  import core_pkg::*;
(
  input  sb_slot_t             slot,
  input  logic [REG_IDX_W-1:0] src,
  input  logic                 src_vld,
  output logic                 hit,
  output logic                 is_load
);

  // A hit needs a live, register-writing producer whose destination is the source.
  assign hit     = src_vld & slot.vld & slot.wb_en & (slot.dest == src);
  assign is_load = hit & slot.mem_r;

endmodule

// File: rtl/id_exe_hazard_ctrl.sv
// ID/EXE hazard controller: tracks the instructions in EXE and MEM, decides
// forwarding selects, bubbles/freezes on RAW hazards, flushes on taken
// branches and holds everything during memory waits.
module id_exe_hazard_ctrl
  import core_pkg::*;
#(
  parameter bit FORWARD_EN = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_wb_en,
  input  logic                 id_mem_r_en,
  input  logic [REG_IDX_W-1:0] id_dest,
  input  logic [REG_IDX_W-1:0] id_src1,
  input  logic [REG_IDX_W-1:0] id_src2,
  input  logic                 id_src1_vld,
  input  logic                 id_src2_vld,
  input  logic                 branch_taken,
  input  logic                 mem_ready,
  output logic                 freeze,
  output logic                 flush_if,
  output logic                 flush_id,
  output logic                 stall_all,
  output logic [1:0]           fwd_sel_a,
  output logic [1:0]           fwd_sel_b,
  output logic [CNT_W-1:0]     stall_cnt
);

  // The WB occupant is never compared (the regfile writes before it reads),
  // so only the EXE and MEM slots need storage.
  sb_slot_t         exe_q, exe_d, mem_q, mem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  sb_slot_t [1:0]                  slots;    // [0]=EXE, [1]=MEM
  logic     [1:0][REG_IDX_W-1:0]   src_idx;  // [0]=src1, [1]=src2
  logic     [1:0]                  src_vld;
  logic     [1:0][1:0]             hit, ld, stl;  // [slot][src]
  logic                            hz;
  logic     [1:0][1:0]             sel;

  assign slots   = {mem_q, exe_q};
  assign src_idx = {id_src2, id_src1};
  assign src_vld = {id_src2_vld, id_src1_vld};

  // Every slot/source pair gets a comparator; a pair stalls when forwarding
  // is off, or when the producer is a load still in EXE (data not ready).
  for (genvar j = 0; j < 2; j++) begin : g_slot
    for (genvar i = 0; i < 2; i++) begin : g_src
      hz_match u_match (
        .slot    (slots[j]),
        .src     (src_idx[i]),
        .src_vld (src_vld[i]),
        .hit     (hit[j][i]),
        .is_load (ld[j][i])
      );
      assign stl[j][i] = hit[j][i] & (FORWARD_EN ? (ld[j][i] & (j == 0)) : 1'b1);
    end
  end

  assign hz = |stl;

  // Forwarding select per source: the youngest producer (EXE) wins over MEM.
  always_comb begin
    sel = '{default: FWD_REGFILE};
    if (FORWARD_EN) begin
      for (int i = 0; i < 2; i++) begin
        if (hit[0][i])      sel[i] = ld[0][i] ? FWD_REGFILE : FWD_EXE;
        else if (hit[1][i]) sel[i] = FWD_MEM;
      end
    end
  end

  assign fwd_sel_a = sel[0];
  assign fwd_sel_b = sel[1];

  // Pipeline control, highest priority first: memory wait, branch, hazard.
  always_comb begin
    freeze    = 1'b0;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    stall_all = 1'b0;
    if (!mem_ready) begin
      stall_all = 1'b1;
    end else if (branch_taken) begin
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (hz) begin
      freeze   = 1'b1;
      flush_id = 1'b1;
    end
  end

  // Scoreboard advance and saturating stall counter; both hold during memory waits.
  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (mem_ready) begin
      mem_d = exe_q;
      exe_d = flush_id ? '0 : '{vld: 1'b1, wb_en: id_wb_en, mem_r: id_mem_r_en, dest: id_dest};
      if (hz && !branch_taken && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_q <= '0;
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_exe_hazard_ctrl.sv
// Bench for id_exe_hazard_ctrl: one forwarding instance (32-bit counter) and
// one non-forwarding instance (3-bit counter) share the same stimulus.
module tb_id_exe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_wb_en, id_mem_r_en, id_src1_vld, id_src2_vld;
  logic [3:0] id_dest, id_src1, id_src2;
  logic       branch_taken, mem_ready;

  logic        freeze_f, flush_if_f, flush_id_f, stall_all_f;
  logic [1:0]  sel_a_f, sel_b_f;
  logic [31:0] cnt_f;
  logic        freeze_n, flush_if_n, flush_id_n, stall_all_n;
  logic [1:0]  sel_a_n, sel_b_n;
  logic [2:0]  cnt_n;

  logic [7:0] obs_f, obs_n;
  assign obs_f = {freeze_f, flush_if_f, flush_id_f, stall_all_f, sel_a_f, sel_b_f};
  assign obs_n = {freeze_n, flush_if_n, flush_id_n, stall_all_n, sel_a_n, sel_b_n};

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  id_exe_hazard_ctrl #(.FORWARD_EN(1'b1), .CNT_W(32)) u_f (
    .clk(clk), .rst(rst), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_vld(id_src1_vld), .id_src2_vld(id_src2_vld),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .freeze(freeze_f), .flush_if(flush_if_f), .flush_id(flush_id_f),
    .stall_all(stall_all_f), .fwd_sel_a(sel_a_f), .fwd_sel_b(sel_b_f),
    .stall_cnt(cnt_f));

  id_exe_hazard_ctrl #(.FORWARD_EN(1'b0), .CNT_W(3)) u_n (
    .clk(clk), .rst(rst), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_vld(id_src1_vld), .id_src2_vld(id_src2_vld),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .freeze(freeze_n), .flush_if(flush_if_n), .flush_id(flush_id_n),
    .stall_all(stall_all_n), .fwd_sel_a(sel_a_n), .fwd_sel_b(sel_b_n),
    .stall_cnt(cnt_n));

  // Reference model: per config (0 = forwarding, 1 = none) the instructions
  // issued 1 and 2 cycles ago; a source's producer distance decides everything.
  bit    m_vld[2][2], m_wb[2][2], m_ld[2][2];
  int    m_dst[2][2];
  longint m_cnt[2];
  longint m_cap[2] = '{64'hFFFF_FFFF, 7};

  function automatic void m_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 2; k++) begin
        m_vld[c][k] = 0; m_wb[c][k] = 0; m_ld[c][k] = 0; m_dst[c][k] = 0;
      end
      m_cnt[c] = 0;
    end
  endfunction

  // Returns {freeze, flush_if, flush_id, stall_all, sel_a, sel_b}; lu marks
  // sources whose select is don't-care because they wait on a load.
  function automatic logic [7:0] m_eval(int c, output bit hz, output bit [1:0] lu);
    int  r[2];
    bit  v[2];
    int  sel[2];
    int  d;
    logic [7:0] o;
    r = '{int'(id_src1), int'(id_src2)};
    v = '{id_src1_vld, id_src2_vld};
    hz = 0; lu = 2'b00; sel = '{0, 0};
    for (int s = 0; s < 2; s++) begin
      d = 0;
      for (int k = 0; k < 2; k++)
        if (d == 0 && v[s] && m_vld[c][k] && m_wb[c][k] && m_dst[c][k] == r[s]) d = k + 1;
      if (c == 0) begin
        if (d == 1 && m_ld[c][0]) begin hz = 1; lu[s] = 1; end
        else sel[s] = d;
      end else if (d != 0) hz = 1;
    end
    o = {6'b0, 2'b0};
    if (!mem_ready)        o[4] = 1;
    else if (branch_taken) begin o[6] = 1; o[5] = 1; end
    else if (hz)           begin o[7] = 1; o[5] = 1; end
    o[3:2] = 2'(sel[0]);
    o[1:0] = 2'(sel[1]);
    return o;
  endfunction

  function automatic void m_clock(int c, bit flush, bit hz);
    if (!mem_ready) return;
    m_vld[c][1] = m_vld[c][0]; m_wb[c][1] = m_wb[c][0];
    m_ld[c][1]  = m_ld[c][0];  m_dst[c][1] = m_dst[c][0];
    m_vld[c][0] = !flush; m_wb[c][0] = id_wb_en; m_ld[c][0] = id_mem_r_en;
    m_dst[c][0] = int'(id_dest);
    if (hz && !branch_taken && m_cnt[c] < m_cap[c]) m_cnt[c]++;
  endfunction

  task automatic set_id(bit wb, bit ld, int dst, int s1, bit v1, int s2, bit v2);
    id_wb_en = wb; id_mem_r_en = ld; id_dest = 4'(dst);
    id_src1 = 4'(s1); id_src1_vld = v1; id_src2 = 4'(s2); id_src2_vld = v2;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0);
    branch_taken = 0; mem_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk); rst = 1; #2; rst = 0;
    tick();
  endtask

  task automatic test_reset();
    idle(); rst = 1; #12;
    checks++; if (obs_f !== 8'h00 || cnt_f !== 32'd0) begin
      fails++; $display("FAIL reset_f: ctrl=%b cnt=%0d required ctrl=0 cnt=0", obs_f, cnt_f); end
    checks++; if (obs_n !== 8'h00 || cnt_n !== 3'd0) begin
      fails++; $display("FAIL reset_n: ctrl=%b cnt=%0d required ctrl=0 cnt=0", obs_n, cnt_n); end
    rst = 0; tick();
    @(negedge clk);
    checks++; if (obs_f !== 8'h00 || cnt_f !== 32'd0) begin
      fails++; $display("FAIL idle_f: ctrl=%b cnt=%0d required 0 0", obs_f, cnt_f); end
    // Reset mid-stall on the non-forwarding instance.
    tick();
    set_id(1, 0, 1, 0, 0, 0, 0); tick();
    set_id(1, 0, 6, 1, 1, 0, 0); tick();
    @(negedge clk);
    checks++; if (freeze_n !== 1'b1 || cnt_n !== 3'd1) begin
      fails++; $display("FAIL pre_rst_stall: freeze=%b cnt=%0d required 1 1", freeze_n, cnt_n); end
    #1 rst = 1; #1;
    checks++; if (obs_n !== 8'h00 || cnt_n !== 3'd0 || obs_f !== 8'h00) begin
      fails++; $display("FAIL rst_mid_stall: n=%b cnt=%0d f=%b required all 0", obs_n, cnt_n, obs_f); end
    #1 rst = 0;
    tick(); @(negedge clk);
    checks++; if (freeze_n !== 1'b0) begin
      fails++; $display("FAIL stale_hazard: freeze=%b required 0", freeze_n); end
  endtask

  task automatic test_forward();
    do_reset();
    set_id(1, 0, 1, 0, 0, 0, 0); tick();           // ADD R1
    set_id(1, 0, 2, 1, 1, 3, 1);                   // SUB R2,R1,R3
    @(negedge clk);
    checks++; if (obs_f !== 8'b0000_01_00) begin
      fails++; $display("FAIL fwd_exe: ctrl=%b required 00000100", obs_f); end
    tick();
    set_id(1, 0, 7, 5, 1, 1, 1);                   // reads R1 as src2
    @(negedge clk);
    checks++; if (obs_f !== 8'b0000_00_10) begin
      fails++; $display("FAIL fwd_mem: ctrl=%b required 00000010", obs_f); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 1, 4, 0, 0, 0, 0); tick();           // LDR R4
    set_id(1, 0, 5, 4, 1, 4, 1);                   // ADD R5,R4,R4
    @(negedge clk);
    checks++; if (obs_f[7:4] !== 4'b1010 || cnt_f !== 32'd0) begin
      fails++; $display("FAIL load_use_stall: ctrl=%b cnt=%0d required 1010xxxx 0", obs_f, cnt_f); end
    tick(); @(negedge clk);
    checks++; if (obs_f !== 8'b0000_10_10 || cnt_f !== 32'd1) begin
      fails++; $display("FAIL load_use_after: ctrl=%b cnt=%0d required 00001010 1", obs_f, cnt_f); end
  endtask

  task automatic test_no_forward();
    do_reset();
    set_id(1, 0, 1, 0, 0, 0, 0); tick();           // ADD R1
    set_id(1, 0, 6, 1, 1, 0, 0);                   // ORR R6,R1
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (obs_n !== 8'b1010_0000 || cnt_n !== 3'(k)) begin
        fails++; $display("FAIL nofwd_stall%0d: ctrl=%b cnt=%0d required 10100000 %0d", k, obs_n, cnt_n, k); end
      tick();
    end
    @(negedge clk);
    checks++; if (obs_n !== 8'h00 || cnt_n !== 3'd2) begin
      fails++; $display("FAIL nofwd_release: ctrl=%b cnt=%0d required 0 2", obs_n, cnt_n); end
  endtask

  task automatic test_branch();
    do_reset();
    set_id(1, 1, 4, 0, 0, 0, 0); tick();
    set_id(1, 0, 5, 4, 1, 0, 0); branch_taken = 1;
    @(negedge clk);
    checks++; if (obs_f[7:4] !== 4'b0110) begin
      fails++; $display("FAIL branch_over_hz: ctrl=%b required 0110xxxx", obs_f); end
    tick(); idle(); @(negedge clk);
    checks++; if (obs_f !== 8'h00 || cnt_f !== 32'd0) begin
      fails++; $display("FAIL branch_after: ctrl=%b cnt=%0d required 0 0", obs_f, cnt_f); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    set_id(1, 1, 4, 0, 0, 0, 0); tick();
    set_id(1, 0, 5, 4, 1, 4, 1); mem_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (obs_f[7:4] !== 4'b0001 || cnt_f !== 32'd0) begin
        fails++; $display("FAIL mem_wait%0d: ctrl=%b cnt=%0d required 0001xxxx 0", k, obs_f, cnt_f); end
      tick();
    end
    mem_ready = 1; @(negedge clk);
    checks++; if (obs_f[7:4] !== 4'b1010) begin
      fails++; $display("FAIL mem_wait_resume: ctrl=%b required 1010xxxx", obs_f); end
    tick(); @(negedge clk);
    checks++; if (obs_f !== 8'b0000_10_10 || cnt_f !== 32'd1) begin
      fails++; $display("FAIL mem_wait_after: ctrl=%b cnt=%0d required 00001010 1", obs_f, cnt_f); end
  endtask

  task automatic test_saturate();
    do_reset();
    set_id(1, 0, 1, 1, 1, 0, 0);                   // ORR R1,R1 repeated: self-dependent chain
    repeat (15) tick();
    @(negedge clk);
    checks++; if (cnt_n !== 3'd7) begin
      fails++; $display("FAIL saturate: cnt=%0d required 7", cnt_n); end
  endtask

  task automatic test_random();
    bit hz[2];
    bit [1:0] lu;
    logic [7:0] e, o, msk;
    longint oc;
    bit fl[2];
    do_reset(); m_reset();
    for (int n = 0; n < 800; n++) begin
      set_id($urandom % 4 != 0, $urandom % 3 == 0, $urandom % 4,
             $urandom % 4, $urandom % 3 != 0, $urandom % 4, $urandom % 2 == 0);
      branch_taken = ($urandom % 8 == 0);
      mem_ready    = ($urandom % 5 != 0);
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        e   = m_eval(c, hz[c], lu);
        fl[c] = e[5];
        msk = {4'hF, lu[0] ? 2'b00 : 2'b11, lu[1] ? 2'b00 : 2'b11};
        o   = (c == 0) ? obs_f : obs_n;
        oc  = (c == 0) ? longint'(cnt_f) : longint'(cnt_n);
        checks++;
        if ((o & msk) !== (e & msk) || oc != m_cnt[c]) begin
          fails++;
          $display("FAIL random[%0d] cfg%0d: ctrl=%b cnt=%0d required ctrl=%b cnt=%0d",
                   n, c, o & msk, oc, e & msk, m_cnt[c]);
        end
      end
      @(posedge clk);
      for (int c = 0; c < 2; c++) m_clock(c, fl[c], hz[c]);
      #1;
    end
  endtask

  initial begin
    rst = 0;
    idle();
    test_reset();
    test_forward();
    test_load_use();
    test_no_forward();
    test_branch();
    test_mem_wait();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
